// File: rtl/serial_shifter_pkg.sv
// Shared definitions for the iterative one-bit-per-cycle shift unit:
// operation codes, FSM state encoding and default widths.
package serial_shifter_pkg;

    // Default data width and number of shift-amount bits that count.
    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    // Shift operation selected by the controller.
    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_PASS = 2'b11
    } shift_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_FIN   = 2'b10
    } shift_state_e;

endpackage : serial_shifter_pkg

// File: rtl/serial_shifter.sv
// Iterative shift unit: latches operand, amount and operation on an accepted
// start, shifts one bit per cycle, then pulses done with the final value.
// The visible result only changes on entry to FIN, so the ALUOut mux never
// sees a partially shifted word.
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SHW   = AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       shiftop,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] amt32,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    shift_state_e     state_q,  state_d;
    shift_op_e        op_q,     op_d;
    logic [WIDTH-1:0] work_q,   work_d;
    logic [SHW-1:0]   count_q,  count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] step;

    // Upper amount bits come from the extender and carry no information.
    logic unused_amt_hi;
    assign unused_amt_hi = ^amt32[WIDTH-1:SHW];

    // One-bit step of the latched operation.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        step = work_q;
        case (op_q)
            SHIFT_SLL: step = {work_q[WIDTH-2:0], 1'b0};
            SHIFT_SRL: step = {1'b0, work_q[WIDTH-1:1]};
            SHIFT_SRA: step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default:   step = work_q;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state here is reset, including the result, so an aborted
        // operation leaves no stale value behind.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= SHIFT_SLL;
            work_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        count_d  = count_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                // FIN falls back to IDLE, but may also accept a new request.
                state_d = ST_IDLE;
                if (start) begin
                    work_d  = data_in;
                    count_d = amt32[SHW-1:0];
                    op_d    = shift_op_e'(shiftop);
                    if (amt32[SHW-1:0] == '0 || shiftop == SHIFT_PASS) begin
                        state_d  = ST_FIN;
                        result_d = data_in;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                // start is ignored here; the last step goes straight to result.
                work_d  = step;
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d  = ST_FIN;
                    result_d = step;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = (state_q == ST_FIN);
    end

    assign result = result_q;

endmodule : serial_shifter

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: directed table, randomized ops
// against a behavioural model, and multi-cycle corner sequences.
module tb_serial_shifter;
    import serial_shifter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  shiftop;
    logic [31:0] data_in;
    logic [31:0] amt32;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    serial_shifter u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .shiftop(shiftop),
        .data_in(data_in),
        .amt32  (amt32),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] amt;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain shift operators on the low 5 amount bits.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                              input logic [31:0] a);
        int n;
        logic [31:0] r;
        n = int'(a % 32);
        case (op)
            2'b00:   r = d << n;
            2'b01:   r = d >> n;
            2'b10:   r = $signed(d) >>> n;
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a);
        if (op == 2'b11) return 0;
        return int'(a % 32);
    endfunction

    // Issue one op, scramble inputs after acceptance, measure latency/busy.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                          input logic [31:0] a, input logic [31:0] exp, input int lat);
        int cycles;
        int busy_cnt;
        logic hold_ok;
        logic [31:0] prev;
        @(negedge clk);
        prev    = result;
        start   = 1'b1;
        shiftop = op;
        data_in = d;
        amt32   = a;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = $urandom;
        amt32   = $urandom;
        shiftop = 2'($urandom_range(0, 3));
        cycles   = 0;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (done) break;
            if (busy) busy_cnt++;
            if (result !== prev) hold_ok = 1'b0;
        end
        check({name, " latency"}, 32'(cycles), 32'(lat + 1));
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'(lat));
        check({name, " result"}, result, exp);
        check({name, " result_hold"}, {31'd0, hold_ok}, 32'd1);
        @(negedge clk);
        check({name, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cnt;
        int gap;
        logic [1:0]  rop;
        logic [31:0] rd;
        logic [31:0] ra;

        vecs[0] = '{2'b00, 32'h0000_0001, 32'd4,          32'h0000_0010, 4};
        vecs[1] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 31};
        vecs[2] = '{2'b01, 32'h8000_0000, 32'd31,         32'h0000_0001, 31};
        vecs[3] = '{2'b01, 32'h1234_5678, 32'd0,          32'h1234_5678, 0};
        vecs[4] = '{2'b11, 32'hDEAD_BEEF, 32'd7,          32'hDEAD_BEEF, 0};
        vecs[5] = '{2'b10, 32'h7000_0000, 32'd4,          32'h0700_0000, 4};
        vecs[6] = '{2'b10, 32'hF000_0000, 32'h0000_0024,  32'hFF00_0000, 4};
        vecs[7] = '{2'b00, 32'hFFFF_FFFF, 32'd31,         32'h8000_0000, 31};
        vecs[8] = '{2'b01, 32'hA5A5_A5A5, 32'd1,          32'h52D2_D2D2, 1};

        rst_n   = 1'b0;
        start   = 1'b0;
        shiftop = 2'b00;
        data_in = 32'h0;
        amt32   = 32'h0;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        #12;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].amt,
                   vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rd  = $urandom;
            ra  = $urandom;
            run_op($sformatf("rand%0d", i), rop, rd, ra, ref_shift(rop, rd, ra),
                   ref_latency(rop, ra));
        end

        // Start pulsed during SHIFT must be ignored.
        @(negedge clk);
        start = 1'b1; shiftop = 2'b00; data_in = 32'h1; amt32 = 32'd8;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; shiftop = 2'b01; data_in = 32'h0000_FFFF; amt32 = 32'd2;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                check("ignore result", result, 32'h0000_0100);
            end
        end
        check("ignore done_count", 32'(cnt), 32'd1);

        // start held through FIN: back-to-back ops.
        @(negedge clk);
        start = 1'b1; shiftop = 2'b01; data_in = 32'h0000_00F0; amt32 = 32'd3;
        @(posedge clk); #1;
        shiftop = 2'b00; data_in = 32'h0000_0003; amt32 = 32'd5;
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (done) break;
        end
        check("b2b first_latency", 32'(cnt), 32'd4);
        check("b2b first_result", result, 32'h0000_001E);
        @(posedge clk); #1 start = 1'b0;
        gap = 0;
        while (gap < 40) begin
            @(negedge clk);
            gap++;
            if (done) break;
        end
        check("b2b done_gap", 32'(gap), 32'd6);
        check("b2b second_result", result, 32'h0000_0060);

        // Asynchronous reset in the middle of SHIFT aborts the op.
        @(negedge clk);
        start = 1'b1; shiftop = 2'b00; data_in = 32'h3; amt32 = 32'd20;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("abort no_done", 32'(cnt), 32'd0);
        run_op("after_reset", 2'b10, 32'h8000_00F0, 32'd8, 32'hFF80_0000, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_shifter
